mem_port_arbiter: RTL

//  Shares the CPU's single word-addressed memory between instruction fetch (IF) and data load/store (D).

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_age_counter.sv | 23 ++
 rtl/mem_port_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and arbitration-mode constants for mem_port_arbiter
//   owner_t   : which port owns the read data returning next cycle
//   ARB_DPRIO : D-priority with IF starvation guard
//   ARB_RR    : strict round-robin between IF and D
package mem_arb_pkg;
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_t;
    localparam int ARB_DPRIO = 0;
    localparam int ARB_RR    = 1;
endpackage

// File: rtl/mem_port_arbiter_age_counter.sv
// arb_age_counter: saturating count of consecutive cycles the IF port was denied
//   clk, reset : clock and asynchronous active-low reset
//   inc        : IF requested but was not granted this cycle
//   clr        : IF granted this cycle (takes precedence over inc)
//   cnt        : current age, saturates at LIM
module arb_age_counter #(
    parameter int LIM = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != 4'(LIM))
            cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-addressed memory between instruction fetch and data ports
//   clk, reset            : clock and asynchronous active-low reset
//   if_req/if_addr        : fetch request; if_gnt accepts it, if_rvalid/if_rdata return it next cycle
//   d_req/d_we/d_addr/... : load/store request; d_gnt accepts it, d_rvalid/d_rdata return loads
//   mem_*                 : memory bus, one access per cycle, read data one cycle after the access
//   conflict_cnt          : saturating count of cycles in which both ports requested
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RR_MODE    = 0,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);
    owner_t     owner, rr_last;
    logic [3:0] starve_cnt;
    logic       if_pick;

    // Tie-break used only when both ports request in the same cycle.
    assign if_pick = (RR_MODE == ARB_RR) ? (rr_last == OWN_D) : (starve_cnt == 4'(STARVE_LIM));

    // Grants are forced low while reset is asserted, so nothing leaks onto the memory bus.
    assign if_gnt    = reset & if_req & (!d_req | if_pick);
    assign d_gnt     = reset & d_req & !if_gnt;
    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_wdata;

    assign if_rvalid = (owner == OWN_IF);
    assign d_rvalid  = (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    arb_age_counter #(.LIM(STARVE_LIM)) u_age (
        .clk   (clk),
        .reset (reset),
        .inc   (if_req & !if_gnt),
        .clr   (if_gnt),
        .cnt   (starve_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner        <= OWN_NONE;
            rr_last      <= OWN_IF;
            conflict_cnt <= '0;
        end else begin
            owner        <= if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
            rr_last      <= if_gnt ? OWN_IF : d_gnt ? OWN_D : rr_last;
            if (if_req && d_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule
